// File: rtl/instr_queue.sv
// instr_queue: circular FIFO between the instruction fetcher and the decoder.
// Holds fetched {instr, pc} pairs and issues at most one per cycle to the
// decoder as a one-cycle decode_enable pulse with registered instr/pc.
// A pipeline state update (update_stat) flushes the whole queue.
// Optional feature: define INSTR_QUEUE_BYPASS_EN to forward a fetched word
// straight to the decoder when the queue is empty (one-edge latency).
module instr_queue #(
  parameter int DEPTH_LOG    = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 update_stat,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_instr,
  input  logic [31:0]          fetch_pc,
  input  logic                 dispatch_stall,
  output logic                 full,
  output logic                 almost_full,
  output logic                 decode_enable,
  output logic [31:0]          instr,
  output logic [31:0]          pc,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   DEPTH_C  = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   MARGIN_C = (DEPTH_LOG + 1)'(AFULL_MARGIN);
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);

  // Entry storage; contents are deliberately left unreset.
  logic [31:0] memInstr [DEPTH];
  logic [31:0] memPc    [DEPTH];

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 decEn_q, decEn_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          pc_q, pc_d;
  logic                 full_q, full_d;
  logic                 afull_q, afull_d;

  logic active;
  logic doPush;
  logic doPop;
  logic doBypass;

  // Decide what happens at the coming edge: push, pop and (optionally) bypass,
  // all judged against the pre-edge occupancy.
  always_comb begin
    active = rdy && !update_stat;
`ifdef INSTR_QUEUE_BYPASS_EN
    doBypass = active && (count_q == '0) && fetch_valid && !dispatch_stall;
`else
    doBypass = 1'b0;
`endif
    doPush = active && fetch_valid && (count_q != DEPTH_C) && !doBypass;
    doPop  = active && (count_q != '0) && !dispatch_stall;
  end

  // Next-state for pointers, occupancy and the registered decoder outputs.
  // Freeze (rdy low) holds everything except the pulse, which drops.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    decEn_d = 1'b0;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (rdy && update_stat) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        tail_d = tail_q + PTR_ONE;
      end
      if (doPop) begin
        head_d  = head_q + PTR_ONE;
        instr_d = memInstr[head_q];
        pc_d    = memPc[head_q];
        decEn_d = 1'b1;
      end
      if (doBypass) begin
        instr_d = fetch_instr;
        pc_d    = fetch_pc;
        decEn_d = 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == DEPTH_C);
    afull_d = ((DEPTH_C - count_d) <= MARGIN_C);
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      decEn_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      decEn_q <= decEn_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

  // Write an accepted fetch into the slot at the tail.
  always_ff @(posedge clk) begin
    if (doPush) begin
      memInstr[tail_q] <= fetch_instr;
      memPc[tail_q]    <= fetch_pc;
    end
  end

  assign full          = full_q;
  assign almost_full   = afull_q;
  assign decode_enable = decEn_q;
  assign instr         = instr_q;
  assign pc            = pc_q;
  assign count         = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed bench for instr_queue with a queue-based reference
// model compared on every falling edge, plus literal spot checks.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        update_stat;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        dispatch_stall;
  logic        full;
  logic        almost_full;
  logic        decode_enable;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  count;

  int testsRun    = 0;
  int testsFailed = 0;
  bit compareOn   = 1'b0;

  logic [63:0] modelQ[$];
  logic        expEn;
  logic [31:0] expInstr;
  logic [31:0] expPc;
  logic [31:0] decoded[$];
  int          preSize;
  logic [63:0] headEntry;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  instr_queue #(.DEPTH_LOG(4), .AFULL_MARGIN(2)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .update_stat(update_stat),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc),
    .dispatch_stall(dispatch_stall),
    .full(full),
    .almost_full(almost_full),
    .decode_enable(decode_enable),
    .instr(instr),
    .pc(pc),
    .count(count)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] ins, input logic [31:0] p,
                               input logic stall, input logic upd, input logic rdyv);
    fetch_valid    = fv;
    fetch_instr    = ins;
    fetch_pc       = p;
    dispatch_stall = stall;
    update_stat    = upd;
    rdy            = rdyv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reference model: a plain FIFO queue stepped at each edge from the
  // pre-edge inputs; the expected decoder outputs come from what leaves it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      expEn    = 1'b0;
      expInstr = 32'h0;
      expPc    = 32'h0;
    end else if (!rdy) begin
      expEn = 1'b0;
    end else if (update_stat) begin
      modelQ.delete();
      expEn = 1'b0;
    end else begin
      preSize = modelQ.size();
      expEn   = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
      if (preSize == 0 && fetch_valid && !dispatch_stall) begin
        expEn    = 1'b1;
        expInstr = fetch_instr;
        expPc    = fetch_pc;
      end else
`endif
      begin
        if (preSize > 0 && !dispatch_stall) begin
          headEntry = modelQ.pop_front();
          expEn     = 1'b1;
          expInstr  = headEntry[63:32];
          expPc     = headEntry[31:0];
        end
        if (fetch_valid && preSize < 16) modelQ.push_back({fetch_instr, fetch_pc});
      end
    end
  end

  // Compare every DUT output against the model mid-cycle and log decoded PCs.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("decode_enable", 64'(decode_enable), 64'(expEn));
      checkOutput("instr", 64'(instr), 64'(expInstr));
      checkOutput("pc", 64'(pc), 64'(expPc));
      checkOutput("count", 64'(count), 64'(modelQ.size()));
      checkOutput("full", 64'(full), 64'(modelQ.size() == 16));
      checkOutput("almost_full", 64'(almost_full), 64'((16 - modelQ.size()) <= 2));
      if (decode_enable) decoded.push_back(pc);
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    update_stat = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = 32'h0;
    fetch_pc = 32'h0;
    dispatch_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_decode_enable", 64'(decode_enable), 64'd0);
    checkOutput("reset_full", 64'(full), 64'd0);
    checkOutput("reset_almost_full", 64'(almost_full), 64'd0);
    checkOutput("reset_instr", 64'(instr), 64'd0);
    checkOutput("reset_pc", 64'(pc), 64'd0);
    rst = 1'b0;
    compareOn = 1'b1;

    // Push-to-decode latency on an empty queue.
    applyStimulus(1'b1, 32'h00500093, 32'h40, 1'b0, 1'b0, 1'b1);
`ifdef INSTR_QUEUE_BYPASS_EN
    checkOutput("bypass_enable", 64'(decode_enable), 64'd1);
    checkOutput("bypass_instr", 64'(instr), 64'h00500093);
    checkOutput("bypass_pc", 64'(pc), 64'h40);
    checkOutput("bypass_count", 64'(count), 64'd0);
`else
    checkOutput("latency_enable_early", 64'(decode_enable), 64'd0);
    checkOutput("latency_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("latency_enable", 64'(decode_enable), 64'd1);
    checkOutput("latency_instr", 64'(instr), 64'h00500093);
    checkOutput("latency_pc", 64'(pc), 64'h40);
    checkOutput("latency_count_after", 64'(count), 64'd0);
`endif
    idle(2);

    // Ordering across wrap-around with intermittent stalls.
    decoded.delete();
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 32'h1000 + i, 32'(4 * i), (i % 4) == 1, 1'b0, 1'b1);
    idle(30);
    checkOutput("order_len", 64'(decoded.size()), 64'd40);
    for (int i = 0; i < 40 && i < decoded.size(); i++)
      checkOutput("order_pc", 64'(decoded[i]), 64'(4 * i));

    // Full boundary: 17 pushes under stall, the 17th is dropped.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 32'hA000 + i, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
      checkOutput("fill_count", 64'(count), 64'((i + 1 > 16) ? 16 : i + 1));
      checkOutput("fill_full", 64'(full), 64'(i + 1 >= 16));
      checkOutput("fill_almost_full", 64'(almost_full), 64'(i + 1 >= 14));
    end
    decoded.delete();
    idle(20);
    checkOutput("drain_len", 64'(decoded.size()), 64'd16);
    if (decoded.size() == 16) begin
      checkOutput("drain_first", 64'(decoded[0]), 64'h200);
      checkOutput("drain_last", 64'(decoded[15]), 64'h23C);
    end

    // Flush with a simultaneous fetch.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'hB000 + i, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    checkOutput("preflush_count", 64'(count), 64'd5);
    decoded.delete();
    applyStimulus(1'b1, 32'hDEAD, 32'h999, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_enable", 64'(decode_enable), 64'd0);
    applyStimulus(1'b1, 32'h13, 32'h100, 1'b0, 1'b0, 1'b1);
    idle(3);
    checkOutput("flush_len", 64'(decoded.size()), 64'd1);
    if (decoded.size() > 0) checkOutput("flush_next_pc", 64'(decoded[0]), 64'h100);

    // Freeze with three entries queued.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'hC000 + i, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    decoded.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h77, 32'h777, 1'b0, 1'b0, 1'b0);
      checkOutput("freeze_count", 64'(count), 64'd3);
      checkOutput("freeze_enable", 64'(decode_enable), 64'd0);
    end
    idle(5);
    checkOutput("thaw_len", 64'(decoded.size()), 64'd3);
    for (int i = 0; i < 3 && i < decoded.size(); i++)
      checkOutput("thaw_pc", 64'(decoded[i]), 64'h300 + 64'(4 * i));

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'hD000 + i, 32'h600 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
    checkOutput("prereset_count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_count", 64'(count), 64'd0);
    checkOutput("async_enable", 64'(decode_enable), 64'd0);
    checkOutput("async_full", 64'(full), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    compareOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
